// File: rtl/usb_tx.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx
// Purpose  : Full-speed USB transmit bit engine (SYNC, payload, EOP) with NRZI
//            encoding and bit stuffing. Define USB_TX_CRC16_EN to append CRC16.
// Revision : 1.0  initial release
// ============================================================================
module usb_tx #(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       r_enable,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int              C_TW   = $clog2(CLKS_PER_BIT);
  localparam logic [C_TW-1:0] C_TMAX = C_TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_CRC     = 3'd3,
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } t_state;

  t_state          r_state, w_state_n;
  logic [C_TW-1:0] r_timer, w_timer_n;
  logic            r_line, w_line_n;
  logic [2:0]      r_ones, w_ones_n;
  logic            r_stuff, w_stuff_n;
  logic [3:0]      r_bitcnt, w_bitcnt_n;
  logic [15:0]     r_shift, w_shift_n;
  logic            r_done, w_done_n;
  logic            r_error, w_error_n;
  logic            w_tick, w_pop, w_send, w_bit;
  logic [3:0]      w_last_idx;

`ifdef USB_TX_CRC16_EN
  logic [15:0] r_crc, w_crc_n;

  // Reflected form of x^16+x^15+x^2+1, one byte LSB first.
  function automatic logic [15:0] f_crc16(input logic [15:0] i_crc, input logic [7:0] i_byte);
    logic [15:0] v_crc;
    v_crc = i_crc;
    for (int k = 0; k < 8; k++) begin
      if (v_crc[0] ^ i_byte[k]) v_crc = (v_crc >> 1) ^ 16'hA001;
      else                      v_crc = v_crc >> 1;
    end
    return v_crc;
  endfunction

  assign w_last_idx = (r_state == S_CRC) ? 4'd15 : 4'd7;
`else
  assign w_last_idx = 4'd7;
`endif

  assign w_tick = (r_timer == C_TMAX);

  always_comb begin
    w_state_n  = r_state;
    w_timer_n  = r_timer;
    w_line_n   = r_line;
    w_ones_n   = r_ones;
    w_stuff_n  = r_stuff;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_done_n   = 1'b0;
    w_error_n  = 1'b0;
    w_pop      = 1'b0;
    w_send     = 1'b0;
    w_bit      = 1'b0;
`ifdef USB_TX_CRC16_EN
    w_crc_n    = r_crc;
`endif
    if (r_state != S_IDLE) w_timer_n = w_tick ? '0 : r_timer + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_empty) begin
            w_error_n = 1'b1;
          end else begin
            w_state_n  = S_SYNC;
            w_timer_n  = '0;
            w_shift_n  = {8'h00, SYNC_BYTE};
            w_bitcnt_n = '0;
            w_stuff_n  = 1'b0;
            w_ones_n   = '0;
            w_send     = 1'b1;
            w_bit      = SYNC_BYTE[0];
`ifdef USB_TX_CRC16_EN
            w_crc_n    = 16'hFFFF;
`endif
          end
        end
      end
      S_SYNC, S_DATA, S_CRC: begin
        if (w_tick) begin
          // A stuff bit takes priority over advancing, so it also precedes EOP.
          if (!r_stuff && r_ones == 3'd6) begin
            w_stuff_n = 1'b1;
            w_send    = 1'b1;
            w_bit     = 1'b0;
          end else if (r_bitcnt != w_last_idx) begin
            w_stuff_n  = 1'b0;
            w_bitcnt_n = r_bitcnt + 4'd1;
            w_shift_n  = r_shift >> 1;
            w_send     = 1'b1;
            w_bit      = r_shift[1];
          end else if (!tx_empty && r_state != S_CRC) begin
            w_pop      = 1'b1;
            w_state_n  = S_DATA;
            w_stuff_n  = 1'b0;
            w_bitcnt_n = '0;
            w_shift_n  = {8'h00, tx_data};
            w_send     = 1'b1;
            w_bit      = tx_data[0];
`ifdef USB_TX_CRC16_EN
            w_crc_n    = f_crc16(r_crc, tx_data);
          end else if (r_state != S_CRC) begin
            w_state_n  = S_CRC;
            w_stuff_n  = 1'b0;
            w_bitcnt_n = '0;
            w_shift_n  = ~r_crc;
            w_send     = 1'b1;
            w_bit      = ~r_crc[0];
`endif
          end else begin
            w_state_n  = S_EOP_SE0;
            w_stuff_n  = 1'b0;
            w_bitcnt_n = '0;
            w_line_n   = 1'b1;
          end
        end
      end
      S_EOP_SE0: begin
        if (w_tick) begin
          if (r_bitcnt == 4'd1) begin
            w_state_n  = S_EOP_J;
            w_bitcnt_n = '0;
          end else begin
            w_bitcnt_n = r_bitcnt + 4'd1;
          end
        end
      end
      S_EOP_J: begin
        if (w_tick) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // NRZI: a 0 toggles the line and breaks the run of ones.
    if (w_send) begin
      if (w_bit) begin
        w_ones_n = w_ones_n + 3'd1;
      end else begin
        w_ones_n = '0;
        w_line_n = ~w_line_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_line   <= 1'b1;
      r_ones   <= '0;
      r_stuff  <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef USB_TX_CRC16_EN
      r_crc    <= 16'hFFFF;
`endif
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_line   <= w_line_n;
      r_ones   <= w_ones_n;
      r_stuff  <= w_stuff_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_done   <= w_done_n;
      r_error  <= w_error_n;
`ifdef USB_TX_CRC16_EN
      r_crc    <= w_crc_n;
`endif
    end
  end

  assign r_enable = w_pop & ~rst;
  assign d_plus   = (r_state == S_EOP_SE0) ? 1'b0 : r_line;
  assign d_minus  = (r_state == S_EOP_SE0) ? 1'b0 : ~r_line;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = r_done;
  assign tx_error = r_error;

endmodule
`default_nettype wire
